// File: rtl/uart_tx_fifo_if.sv
// Interface bundling the write side (from interface_circuit), the uart_tx
// handshake and the FIFO status lines of uart_tx_fifo.
// master: the surrounding logic that writes bytes and returns done ticks.
// slave : the FIFO itself.
interface uart_tx_fifo_if #(
    parameter int DBIT   = 8,
    parameter int FIFO_W = 2
);
    logic              i_wr;
    logic [DBIT-1:0]   i_wr_data;
    logic              i_tx_done_tick;
    logic              o_tx_start;
    logic [DBIT-1:0]   o_tx_data;
    logic              o_full;
    logic              o_empty;
    logic [FIFO_W:0]   o_count;
    logic              o_overflow;

    modport master (
        output i_wr,
        output i_wr_data,
        output i_tx_done_tick,
        input  o_tx_start,
        input  o_tx_data,
        input  o_full,
        input  o_empty,
        input  o_count,
        input  o_overflow
    );

    modport slave (
        input  i_wr,
        input  i_wr_data,
        input  i_tx_done_tick,
        output o_tx_start,
        output o_tx_data,
        output o_full,
        output o_empty,
        output o_count,
        output o_overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit-side byte buffer between interface_circuit and uart_tx.
// Bytes are queued on single-cycle write strobes and handed to uart_tx one at a
// time: a one-cycle tx_start pulse launches the head byte, and the byte is only
// popped once uart_tx reports tx_done_tick, so the in-flight word stays counted.
// Optional feature macro: UART_TX_FIFO_OVF_EN adds a sticky overflow flag that
// is set whenever a write is dropped because the FIFO is full. Without it the
// o_overflow port is tied to 0.
module uart_tx_fifo #(
    parameter int DBIT   = 8,
    parameter int FIFO_W = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    uart_tx_fifo_if.slave   bus
);

    localparam int                DEPTH    = 1 << FIFO_W;
    localparam int                CNT_W    = FIFO_W + 1;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               start_d;

    logic [DBIT-1:0]    mem [DEPTH];
    logic [FIFO_W-1:0]  wr_ptr_q;
    logic [FIFO_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic               tx_start_q;
    logic [DBIT-1:0]    tx_data_q;

    logic               full;
    logic               empty;
    logic               pop;
    logic               wr_ok;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // A pop only happens when the frame in flight completes; done ticks in
    // IDLE are stray and must not disturb the queue.
    assign pop   = (state_q == BUSY) && bus.i_tx_done_tick;

    // A write into a full FIFO is still accepted when the head pops on the
    // same edge, because that pop frees exactly the slot being written.
    assign wr_ok = bus.i_wr && (!full || pop);

    // Storage array: data only, no reset needed.
    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= bus.i_wr_data;
        end
    end

    // Read/write pointers wrap naturally modulo the depth.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + FIFO_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_W'(1);
            end
        end
    end

    // Occupancy counter, including the word currently on the line.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            count_q <= '0;
        end else begin
            unique case ({wr_ok, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: launch the head word from IDLE, wait for done in BUSY.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = BUSY;
                    start_d = 1'b1;
                end
            end
            BUSY: begin
                if (bus.i_tx_done_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered uart_tx drive: start is a single-cycle pulse and the data
    // word is captured with it and held until the next launch.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_start_q <= start_d;
            if (start_d) begin
                tx_data_q <= mem[rd_ptr_q];
            end
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic overflow_q;

    // Sticky drop flag: any write refused while full sets it until reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            overflow_q <= 1'b0;
        end else if (bus.i_wr && !wr_ok) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.o_overflow = overflow_q;
`else
    assign bus.o_overflow = 1'b0;
`endif

    assign bus.o_tx_start = tx_start_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_full     = full;
    assign bus.o_empty    = empty;
    assign bus.o_count    = count_q;

endmodule
